// File: rtl/apb_spi_ctrl_if.sv
// APB3 bus bundle between the CPU-side master and the SPI control register slave.
interface apb_spi_ctrl_if #(
  parameter int PADDR_W = 8,
  parameter int PDATA_W = 32
);
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [PADDR_W-1:0] paddr;
  logic [PDATA_W-1:0] pwdata;
  logic [PDATA_W-1:0] prdata;
  logic               pready;
  logic               pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_spi_ctrl.sv
// APB3 register slave that feeds one byte at a time to an SPI master through a
// start/done handshake and exposes the received byte, status flags and an interrupt.
module apb_spi_ctrl #(
  parameter int PADDR_W = 8,
  parameter int PDATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  apb_spi_ctrl_if.slave       apb,
  output logic [7:0]          spi_data_in,
  output logic                spi_start,
  input  logic                spi_done,
  input  logic [7:0]          spi_rx_data,
  output logic                irq
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_XFER} state_t;

  state_t     r_state;
  logic       r_en;
  logic       r_irq_en;
  logic [7:0] r_tx_hold;
  logic       r_tx_full;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_ovr;
  logic       r_tx_ovf;
  logic [7:0] r_spi_data;
  logic       r_spi_start;

  logic       w_acc;
  logic       w_addr_ok;
  logic [1:0] w_reg;
  logic       w_wr;
  logic       w_rd;
  logic       w_launch;
  logic       w_tx_wr;
  logic       w_tx_ovf;
  logic       w_tx_ok;
  logic       w_rx_rd;
  logic       w_st_wr;
  logic       w_done;
  logic       w_busy;
  logic [7:0] w_status;
  logic       w_unused;

  assign w_acc     = apb.psel & apb.penable;
  assign w_addr_ok = (apb.paddr[PADDR_W-1:4] == '0);
  assign w_reg     = apb.paddr[3:2];
  assign w_wr      = w_acc & apb.pwrite & w_addr_ok;
  assign w_rd      = w_acc & ~apb.pwrite & w_addr_ok;
  assign w_launch  = (r_state == S_IDLE) & r_en & r_tx_full;
  assign w_tx_wr   = w_wr & (w_reg == 2'd1);
  // A launch in this cycle empties the holding byte, so a concurrent write is not an overflow.
  assign w_tx_ovf  = w_tx_wr & r_tx_full & ~w_launch;
  assign w_tx_ok   = w_tx_wr & ~w_tx_ovf;
  assign w_rx_rd   = w_rd & (w_reg == 2'd2);
  assign w_st_wr   = w_wr & (w_reg == 2'd3);
  assign w_done    = (r_state == S_XFER) & spi_done;
  assign w_busy    = (r_state != S_IDLE);
  assign w_status  = {3'b000, r_tx_ovf, r_rx_ovr, r_rx_valid, w_busy, r_tx_full};
  assign w_unused  = ^{apb.pwdata[PDATA_W-1:8], apb.paddr[1:0]};

  always_comb begin
    apb.prdata = '0;
    if (apb.psel & w_addr_ok) begin
      case (w_reg)
        2'd0:    apb.prdata = PDATA_W'({r_irq_en, r_en});
        2'd1:    apb.prdata = '0;
        2'd2:    apb.prdata = PDATA_W'(r_rx_data);
        default: apb.prdata = PDATA_W'(w_status);
      endcase
    end
  end

  assign apb.pready  = 1'b1;
  assign apb.pslverr = w_acc & (~w_addr_ok | w_tx_ovf);
  assign spi_data_in = r_spi_data;
  assign spi_start   = r_spi_start;
  assign irq         = r_irq_en & (r_rx_valid | r_rx_ovr | r_tx_ovf);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_en        <= 1'b0;
      r_irq_en    <= 1'b0;
      r_tx_hold   <= '0;
      r_tx_full   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_spi_data  <= '0;
      r_spi_start <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state     <= S_LAUNCH;
            r_spi_start <= 1'b1;
            r_spi_data  <= r_tx_hold;
          end
        end
        S_LAUNCH: begin
          r_state     <= S_XFER;
          r_spi_start <= 1'b0;
        end
        S_XFER: begin
          if (spi_done) r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_spi_start <= 1'b0;
        end
      endcase

      if (w_wr && w_reg == 2'd0) begin
        r_en     <= apb.pwdata[0];
        r_irq_en <= apb.pwdata[1];
      end

      if (w_tx_ok) begin
        r_tx_hold <= apb.pwdata[7:0];
        r_tx_full <= 1'b1;
      end else if (w_launch) begin
        r_tx_full <= 1'b0;
      end

      // A read coinciding with done consumes the old byte, so the new one is not an overrun.
      if (w_done) begin
        r_rx_data  <= spi_rx_data;
        r_rx_valid <= 1'b1;
      end else if (w_rx_rd) begin
        r_rx_valid <= 1'b0;
      end

      if (w_done && r_rx_valid && !w_rx_rd) r_rx_ovr <= 1'b1;
      else if (w_st_wr && apb.pwdata[3])    r_rx_ovr <= 1'b0;

      if (w_tx_ovf)                         r_tx_ovf <= 1'b1;
      else if (w_st_wr && apb.pwdata[4])    r_tx_ovf <= 1'b0;
    end
  end

endmodule

// File: doc/apb_spi_ctrl.md
# apb_spi_ctrl

APB3 register slave sitting directly upstream of the SPI master. Accepts one transmit byte from the bus, launches an 8-bit SPI transfer through a start/done handshake, captures the received byte and exposes status and an interrupt to software. The SPI master's `data_in` and `m_r_bit` ports are driven and consumed through this block.

## Interface
- `PADDR_W`, default 8: APB address width; only `paddr[3:2]` is decoded, and `paddr[PADDR_W-1:4]` must be zero.
- `PDATA_W`, default 32: APB data width; upper bits read as 0 and are ignored on write.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `psel` in 1: APB select.
- `penable` in 1: APB enable (access phase).
- `pwrite` in 1: 1 = write.
- `paddr` in `PADDR_W`: byte address.
- `pwdata` in `PDATA_W`: write data.
- `prdata` out `PDATA_W`: read data; combinational from the registers, valid in the access phase.
- `pready` out 1: tied to 1 (zero wait states).
- `pslverr` out 1: error flag, valid in the access phase.
- `spi_data_in` out 8: byte to the SPI master; held stable from `spi_start` until `spi_done`.
- `spi_start` out 1: one-cycle launch pulse.
- `spi_done` in 1: one-cycle pulse from the master; the transfer is complete.
- `spi_rx_data` in 8: byte received by the master; sampled in the cycle `spi_done` is high.
- `irq` out 1: level interrupt.

## Operation
- A bus access occurs on the clock edge where `psel & penable` is high. A setup phase with no access has no effect.
- Register map:
  - 0x0 CTRL (RW): bit0 EN, bit1 IRQ_EN.
  - 0x4 TXDATA (WO): bits[7:0]; reads return 0.
  - 0x8 RXDATA (RO): bits[7:0]; a read clears RX_VALID; writes are ignored with no error.
  - 0xC STATUS: bit0 TX_FULL (RO), bit1 BUSY (RO), bit2 RX_VALID (RO), bit3 RX_OVR (W1C), bit4 TX_OVF (W1C).
- Unmapped address, or nonzero `paddr` bits above [3:2]: `pslverr`=1, `prdata`=0, no state change.
- TXDATA write with TX_FULL=1: the write is dropped, `pslverr`=1, TX_OVF is set.
- TXDATA write in the same cycle the holding byte launches: the write is accepted, because the launch frees the buffer.
- Transfer FSM states:
  - IDLE → LAUNCH when EN=1 and TX_FULL=1.
  - LAUNCH (1 cycle): `spi_start`=1, holding byte copied to `spi_data_in`, TX_FULL cleared, then → XFER.
  - XFER: wait for `spi_done`. On `spi_done`, capture `spi_rx_data` into RXDATA and set RX_VALID, then → IDLE.
- Overrun: if RX_VALID=1 when `spi_done` arrives, RX_OVR is set and the new byte overwrites the old one.
- Simultaneous RXDATA read and `spi_done`: the read returns the old byte, the new byte is stored, RX_VALID stays 1, and RX_OVR is not set.
- `spi_done` while in IDLE or LAUNCH: ignored.
- BUSY = (state != IDLE).
- Clearing EN during XFER: the current transfer completes normally; no new launch occurs until EN=1 again.
- `irq` = IRQ_EN & (RX_VALID | RX_OVR | TX_OVF).

## Timing
- Reset values: CTRL=0, TX holding byte=0, TX_FULL=0, RXDATA=0, RX_VALID=0, RX_OVR=0, TX_OVF=0, state=IDLE.
- Output values in reset: `spi_start`=0, `spi_data_in`=0, `irq`=0, `prdata`=0, `pslverr`=0, `pready`=1.
- Reset asserted mid-transfer: immediately returns to IDLE and clears all flags. A later `spi_done` is ignored.
- TXDATA write at edge N with EN=1 and the FSM in IDLE:
  - FSM is in LAUNCH after edge N+1, so `spi_start` is high between edges N+1 and N+2.
  - XFER from edge N+2.
- `spi_done` high at edge M: RX_VALID=1 and BUSY=0 after edge M. The next launch can begin at edge M+1.
- Minimum turnaround, back-to-back with the buffer pre-filled: 2 cycles from `spi_done` to the next `spi_start`.
- W1C: writing 1 clears the bit at the access edge. A set event in the same cycle wins over the clear.

## Test plan
- Reset, then read all 4 registers → 0x0, 0x0, 0x0, 0x0; `irq`=0; `pready`=1.
- CTRL=0x3, TXDATA=0xA5, hold `spi_rx_data`=0x3C and pulse `spi_done` 8 cycles after `spi_start`:
  - `spi_start` is a single pulse 1 cycle after the write; `spi_data_in`=0xA5 throughout.
  - After `spi_done`: STATUS=0x04, `irq`=1. Reading RXDATA returns 0x3C; then STATUS=0x00 and `irq`=0.
- With EN=0, write TXDATA=0x11, then write TXDATA=0x22:
  - Second write gives `pslverr`=1 and STATUS=0x11.
  - Set EN: `spi_data_in`=0x11.
  - Writing STATUS=0x10 clears TX_OVF.
- Two transfers returning 0x01 then 0x02, no RXDATA read in between → STATUS bit3=1, RXDATA=0x02. Writing STATUS=0x08 clears the bit.
- RXDATA read in the same cycle as `spi_done` (new byte 0x77) → the read returns the old byte, RX_VALID=1, RX_OVR=0.
- Assert `reset` during XFER, then pulse `spi_done` → all registers 0, `spi_start` never reasserted. An access to 0x10 gives `pslverr`=1 and `prdata`=0.
